// File: rtl/cmd_sched_pkg.sv
// Shared opcodes, FSM state type and opcode classification for cmd_scheduler.
// Read opcodes return the controller's dout; every other opcode returns 8'h00.
package cmd_sched_pkg;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_RD_P1 = 4'd1;
  localparam logic [3:0] CMD_RD_P2 = 4'd2;
  localparam logic [3:0] CMD_RD_P3 = 4'd3;
  localparam logic [3:0] CMD_RD_P4 = 4'd4;
  localparam logic [3:0] CMD_CLR   = 4'd5;
  localparam logic [3:0] CMD_DIFF  = 4'd6;
  localparam logic [3:0] CMD_PWM1  = 4'd9;
  localparam logic [3:0] CMD_PWM2  = 4'd10;
  localparam logic [3:0] CMD_PWM3  = 4'd11;
  localparam logic [3:0] CMD_PWM4  = 4'd12;
  localparam logic [3:0] CMD_ID    = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    STOP = 2'd2
  } state_t;

  function automatic logic is_read(input logic [3:0] opcode);
    case (opcode)
      CMD_RD_P1, CMD_RD_P2, CMD_RD_P3, CMD_RD_P4, CMD_DIFF, CMD_ID: return 1'b1;
      CMD_NOP, CMD_CLR: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_pwm(input logic [3:0] opcode);
    case (opcode)
      CMD_PWM1, CMD_PWM2, CMD_PWM3, CMD_PWM4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the requester after
// ptr and returns a one-hot grant (all zero when nothing is requested).
module rr_arbiter
  import cmd_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Round-robin sequencer for the 12-bit output-controller command bus.
// Optional watchdog stop sequence enabled with macro CMD_SCHEDULER_WDOG_EN.
module cmd_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int WDOG_CYCLES = 1_000_000
) (
  input  logic                 clk_sm2,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [12*NREQ-1:0]   req_cmd,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [11:0]          cmdata,
  input  logic [7:0]           dout_in,
  output logic                 busy,
  output logic                 wdog_trip
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  if (HOLD_CYCLES < 2) begin : g_hold_chk
    $error("cmd_scheduler: HOLD_CYCLES must be at least 2");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("cmd_scheduler: NREQ must be in 2..8");
  end
  if (WDOG_CYCLES < 1) begin : g_wdog_chk
    $error("cmd_scheduler: WDOG_CYCLES must be positive");
  end

  state_t          state, next_state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic [CW-1:0]   cnt;
  logic [1:0]      stop_idx;
  logic            stop_gap;
  logic [NREQ-1:0] grant;
  logic            trip_pending;
  logic            hold_done;
  logic            hs;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = (rst_n && state == IDLE && !trip_pending) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign hold_done = (cnt == CW'(HOLD_CYCLES - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = PW'(i);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (trip_pending)  next_state = STOP;
        else if (hs)       next_state = HOLD;
      end
      HOLD: if (hold_done) next_state = IDLE;
      STOP: if (!stop_gap && hold_done && stop_idx == 2'd3) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The STOP sequence reuses the hold counter, with a one-cycle NOP gap between
  // commands so it looks exactly like back-to-back requester traffic.
  always_ff @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) begin
      cmdata    <= 12'h000;
      ptr       <= PW'(NREQ - 1);
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= 8'h00;
      stop_idx  <= 2'd0;
      stop_gap  <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (trip_pending) begin
            cmdata   <= {CMD_PWM1, 8'h00};
            cnt      <= '0;
            stop_idx <= 2'd0;
            stop_gap <= 1'b0;
          end else if (hs) begin
            cmdata <= req_cmd[int'(gnt_idx)*12 +: 12];
            ptr    <= gnt_idx;
            cnt    <= '0;
          end
        end
        HOLD: begin
          if (hold_done) begin
            rsp_data       <= is_read(cmdata[11:8]) ? dout_in : 8'h00;
            rsp_valid[ptr] <= 1'b1;
            cmdata         <= {CMD_NOP, 8'h00};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (stop_gap) begin
            cmdata   <= {CMD_PWM1 + {2'b00, stop_idx} + 4'd1, 8'h00};
            stop_idx <= stop_idx + 2'd1;
            cnt      <= '0;
            stop_gap <= 1'b0;
          end else if (hold_done) begin
            cmdata   <= {CMD_NOP, 8'h00};
            stop_gap <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cmdata <= 12'h000;
      endcase
    end
  end

`ifdef CMD_SCHEDULER_WDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WW-1:0] wdog_cnt;
  logic          wdog_pend;
  logic          pwm_done;
  logic          stop_exit;

  assign pwm_done     = (state == HOLD) && hold_done && is_pwm(cmdata[11:8]);
  assign stop_exit    = (state == STOP) && !stop_gap && hold_done && (stop_idx == 2'd3);
  assign trip_pending = wdog_pend;
  assign wdog_trip    = (state == STOP);

  // The counter saturates at the timeout so a trip cannot re-arm mid-STOP;
  // leaving STOP restarts the timeout window.
  always_ff @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt  <= '0;
      wdog_pend <= 1'b0;
    end else begin
      if (stop_exit || pwm_done)                    wdog_cnt <= '0;
      else if (wdog_cnt != WW'(WDOG_CYCLES - 1))    wdog_cnt <= wdog_cnt + 1'b1;
      if (state == IDLE && wdog_pend)               wdog_pend <= 1'b0;
      else if (state != STOP && wdog_cnt == WW'(WDOG_CYCLES - 1)) wdog_pend <= 1'b1;
    end
  end
`else
  assign trip_pending = 1'b0;
  assign wdog_trip    = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: directed scenarios plus a randomized
// run against a transaction-level timeline model and a controller model.
module tb_cmd_scheduler;

  localparam int NREQ = 2;
  localparam int HOLD = 2;
`ifdef CMD_SCHEDULER_WDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 1_000_000;
`endif

  logic                 clk_sm2 = 1'b0;
  logic                 rst_n   = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [12*NREQ-1:0]   req_cmd;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [7:0]           rsp_data;
  logic [11:0]          cmdata;
  logic [7:0]           dout_in = 8'h00;
  logic                 busy;
  logic                 wdog_trip;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pdata [16];
  logic [3:0] op_q;

  cmd_scheduler #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .WDOG_CYCLES(WDOG)) dut (
    .clk_sm2   (clk_sm2),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .cmdata    (cmdata),
    .dout_in   (dout_in),
    .busy      (busy),
    .wdog_trip (wdog_trip)
  );

  always #5 clk_sm2 = ~clk_sm2;

  // Output controller: latches the opcode on a rising edge, drives dout on the next falling edge.
  always @(posedge clk_sm2 or negedge rst_n) begin
    if (!rst_n) op_q <= 4'h0;
    else        op_q <= cmdata[11:8];
  end
  always @(negedge clk_sm2) dout_in <= pdata[op_q];

  function automatic bit tb_is_read(input logic [3:0] op);
    return (op == 4'd1 || op == 4'd2 || op == 4'd3 || op == 4'd4 || op == 4'd6 || op == 4'd15);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [11:0] c0, input logic [11:0] c1);
    req_valid = v;
    req_cmd   = {c1, c0};
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus('0, 12'h000, 12'h000);
    repeat (2) @(posedge clk_sm2);
    #1 rst_n = 1'b1;
  endtask

  task automatic expectTxn(input int who, input logic [11:0] cmd, input logic [7:0] exp_data);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << who;
    @(negedge clk_sm2);
    checkOutput("grant", 32'(req_ready), 32'(oh));
    @(posedge clk_sm2);
    #1 applyStimulus('0, 12'h000, 12'h000);
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk_sm2);
      checkOutput("hold_cmdata", 32'(cmdata), 32'(cmd));
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("hold_busy", 32'(busy), 32'h1);
    end
    @(negedge clk_sm2);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(oh));
    checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
    checkOutput("gap_cmdata", 32'(cmdata), 32'h0);
    @(negedge clk_sm2);
    checkOutput("rsp_pulse_end", 32'(rsp_valid), 32'h0);
  endtask

  // Timeline model: a grant seen in cycle n owns the bus for cycles n+1..n+HOLD
  // and completes in cycle n+HOLD+1, which is also the next arbitration slot.
  task automatic runModel(input int cycles, input bit contention);
    int last, owner, rsp_at, w, j;
    bit active;
    logic [11:0] mcmd;
    logic [7:0]  mrsp;
    logic [NREQ-1:0] exp_ready;
    last = NREQ - 1; active = 1'b0; rsp_at = 0; owner = 0; mcmd = '0; mrsp = '0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk_sm2);
      exp_ready = '0;
      w = -1;
      if (active && n < rsp_at) begin
        checkOutput("m_cmdata", 32'(cmdata), 32'(mcmd));
        checkOutput("m_busy", 32'(busy), 32'h1);
        checkOutput("m_rsp_idle", 32'(rsp_valid), 32'h0);
      end else begin
        if (active && n == rsp_at) begin
          checkOutput("m_rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << owner));
          checkOutput("m_rsp_data", 32'(rsp_data), 32'(mrsp));
          active = 1'b0;
        end else begin
          checkOutput("m_rsp_none", 32'(rsp_valid), 32'h0);
        end
        checkOutput("m_cmdata_gap", 32'(cmdata), 32'h0);
        checkOutput("m_busy_idle", 32'(busy), 32'h0);
        for (int k = 1; k <= NREQ; k++) begin
          j = (last + k) % NREQ;
          if (w < 0 && req_valid[j]) w = j;
        end
        if (w >= 0) begin
          exp_ready = NREQ'(1) << w;
          last   = w;
          owner  = w;
          mcmd   = req_cmd[12*w +: 12];
          mrsp   = tb_is_read(mcmd[11:8]) ? pdata[mcmd[11:8]] : 8'h00;
          active = 1'b1;
          rsp_at = n + HOLD + 1;
        end
      end
      checkOutput("m_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("m_wdog", 32'(wdog_trip), 32'h0);
      @(posedge clk_sm2);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (contention) continue;
        if (i == w) begin
          if ($urandom_range(0, 1) == 1) req_cmd[12*i +: 12] = 12'($urandom);
          else                           req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]        = 1'b1;
          req_cmd[12*i +: 12] = 12'($urandom);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pdata[i] = 8'($urandom_range(1, 255));
    pdata[1] = 8'h5A;

    // Reset with random requests pending
    rst_n = 1'b0;
    applyStimulus(NREQ'($urandom_range(1, 3)), 12'($urandom), 12'($urandom));
    repeat (3) @(negedge clk_sm2);
    checkOutput("rst_cmdata", 32'(cmdata), 32'h0);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_wdog", 32'(wdog_trip), 32'h0);
    @(posedge clk_sm2);
    #1 applyStimulus('0, 12'h000, 12'h000);
    rst_n = 1'b1;

    // Single read from requester 0
    applyStimulus(2'b01, 12'h100, 12'h000);
    expectTxn(0, 12'h100, 8'h5A);

    // PWM write from requester 1 returns zero
    resetDut();
    applyStimulus(2'b10, 12'h000, 12'h980);
    expectTxn(1, 12'h980, 8'h00);

    // Continuous contention alternates grants
    resetDut();
    applyStimulus(2'b11, 12'h200, 12'h300);
    runModel(13, 1'b1);

    // Reset during HOLD drops the command; requester 0 wins afterwards
    resetDut();
    applyStimulus(2'b01, 12'h400, 12'h500);
    @(negedge clk_sm2);
    checkOutput("hr_grant", 32'(req_ready), 32'h1);
    @(posedge clk_sm2);
    #1 applyStimulus(2'b11, 12'h400, 12'h500);
    @(negedge clk_sm2);
    checkOutput("hr_cmdata", 32'(cmdata), 32'h400);
    rst_n = 1'b0;
    #1;
    checkOutput("hr_cmdata_rst", 32'(cmdata), 32'h0);
    checkOutput("hr_busy_rst", 32'(busy), 32'h0);
    checkOutput("hr_ready_rst", 32'(req_ready), 32'h0);
    repeat (3) begin
      @(negedge clk_sm2);
      checkOutput("hr_no_rsp", 32'(rsp_valid), 32'h0);
    end
    @(posedge clk_sm2);
    #1 rst_n = 1'b1;
    @(negedge clk_sm2);
    checkOutput("hr_regrant", 32'(req_ready), 32'h1);

`ifndef CMD_SCHEDULER_WDOG_EN
    // Randomized traffic against the timeline model
    resetDut();
    runModel(400, 1'b0);
`else
    begin
      bit seen;
      logic [11:0] prev;
      logic [11:0] seq [$];
      resetDut();
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk_sm2);
        if (wdog_trip) seen = 1'b1;
      end
      checkOutput("wd_trip_rise", 32'(seen), 32'h1);
      applyStimulus(2'b01, 12'h100, 12'h000);
      prev = 12'h000;
      for (int i = 0; i < 60 && wdog_trip; i++) begin
        checkOutput("wd_ready", 32'(req_ready), 32'h0);
        checkOutput("wd_rsp", 32'(rsp_valid), 32'h0);
        if (cmdata != prev && cmdata != 12'h000) seq.push_back(cmdata);
        prev = cmdata;
        @(negedge clk_sm2);
      end
      checkOutput("wd_stop_exit", 32'(wdog_trip), 32'h0);
      checkOutput("wd_seq_len", 32'(seq.size()), 32'h4);
      for (int i = 0; i < 4; i++)
        checkOutput("wd_seq", 32'((i < seq.size()) ? seq[i] : 12'hFFF), 32'(12'h900 + 12'(i * 256)));
      checkOutput("wd_regrant", 32'(req_ready), 32'h1);
      @(posedge clk_sm2);
      #1 applyStimulus('0, 12'h000, 12'h000);
      @(negedge clk_sm2);
      checkOutput("wd_post_cmd", 32'(cmdata), 32'h100);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_scheduler.md
# cmd_scheduler

Sequences and arbitrates the 12-bit command bus (`cmdata`: opcode [11:8], data [7:0]) that drives the output controller. It shares that bus among NREQ requesters (host link, navigation logic, ...) with round-robin fairness. Each accepted command is held long enough for the controller to act on it, and the controller's `dout` is returned to the requester that issued the command. An optional watchdog forces all four PWM channels to zero if no requester writes PWM for too long.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8
- HOLD_CYCLES, 2: cycles each command is held on `cmdata`. Minimum 2; a value below 2 is an elaboration error.
- WDOG_CYCLES, 1_000_000: watchdog timeout in clocks. Used only with the watchdog macro.

Ports:
- clk_sm2  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request pending, per requester
- req_cmd  in  12*NREQ  command for requester i at [12i+11:12i]
- req_ready  out  NREQ  one-hot grant; handshake completes when valid&&ready at a rising edge
- rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester
- rsp_data  out  8  returned byte, valid while any rsp_valid is high
- cmdata  out  12  command bus to the output controller (registered)
- dout_in  in  8  `dout` from the output controller
- busy  out  1  high whenever the FSM is not in IDLE
- wdog_trip  out  1  high during a watchdog stop sequence

## Operation
- FSM states: IDLE, HOLD, STOP.
- Reset values: state = IDLE, `cmdata` = 12'h000, `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 8'h00, `busy` = 0, `wdog_trip` = 0. The round-robin pointer resets to NREQ-1, so requester 0 is granted first.
- IDLE:
  - `req_ready` is combinational. It is the round-robin grant when any `req_valid` is high and no watchdog trip is pending.
  - The search starts at the requester after the last one granted.
  - On a handshake: `cmdata` <= req_cmd[i], the pointer <= i, the hold counter <= 0, and the FSM moves to HOLD.
- HOLD:
  - `cmdata` stays constant while the counter increments.
  - When the counter reaches HOLD_CYCLES-1:
    - capture the response into `rsp_data` and pulse `rsp_valid[i]`;
    - set `cmdata` <= 12'h000;
    - return to IDLE.
  - Response data:
    - Read opcodes (1, 2, 3, 4, 6, 15): `rsp_data` = `dout_in`.
    - All other opcodes, including undefined ones: `rsp_data` = 8'h00. These are still completed normally.
- Requesters must hold `req_valid` and `req_cmd` stable until `req_ready`. No requester is ever granted twice in a row while another is waiting.
- STOP (watchdog only): issues 12'h900, 12'hA00, 12'hB00, 12'hC00 in that order.
  - Each command uses the same hold and gap timing as a normal transaction.
  - No `rsp_valid` pulses are produced, and `req_ready` stays 0 throughout.
  - Returns to IDLE after 12'hC00 completes.

## Timing
- Handshake at edge t0:
  - `cmdata` = command from t0 through t0+HOLD_CYCLES.
  - Capture and `rsp_valid` at edge t0+HOLD_CYCLES. The `rsp_valid` pulse lasts exactly one cycle.
  - `cmdata` = 12'h000 for at least one cycle between transactions.
- Back-to-back throughput: one command per HOLD_CYCLES+1 cycles.
- Why HOLD_CYCLES ≥ 2: the controller registers the opcode on the first rising edge after t0 and updates `dout` on the following falling edge. `dout_in` is therefore first valid at edge t0+2.
- Reset mid-operation: all outputs return to reset values immediately. The in-flight command is dropped with no `rsp_valid`, and any pending watchdog trip is cleared.
- A request held valid through reset is re-arbitrated after release.

## Configuration
- Macro: CMD_SCHEDULER_WDOG_EN.
- Defined:
  - A timeout counter increments every cycle.
  - It clears on completion of any requester command with opcode 9..12, and on exit from STOP.
  - When the counter reaches WDOG_CYCLES-1, a trip is set pending.
  - A trip that occurs during HOLD waits for that transaction to complete.
  - A pending trip in IDLE takes priority over all requests; the FSM enters STOP and `wdog_trip` = 1 until STOP exits.
- Undefined: no counter and no STOP state; `wdog_trip` is tied to 0 and WDOG_CYCLES is ignored.

## Structure
- Package `cmd_sched_pkg` contains:
  - opcode constants: CMD_NOP=0, CMD_RD_P1..CMD_RD_P4=1..4, CMD_CLR=5, CMD_DIFF=6, CMD_PWM1..CMD_PWM4=9..12, CMD_ID=15;
  - an `is_read(opcode)` function;
  - the FSM state enum.
- Sub-module `rr_arbiter`: inputs are NREQ request bits and the pointer; output is a one-hot grant. It is purely combinational.

## Test plan
- Reset: hold rst_n low with random req_valid -> `cmdata`=12'h000, `req_ready`=0, `rsp_valid`=0, `busy`=0.
- Single read: req0 = 12'h100, controller model pdata1=8'h5A -> `req_ready[0]` at t0, `cmdata`=12'h100 through t0+2, `rsp_valid[0]` at t0+2 with `rsp_data`=8'h5A, then `cmdata`=12'h000.
- Contention: req0=12'h200 and req1=12'h300 held valid continuously -> grants alternate 0,1,0,1 every 3 cycles; `rsp_data` matches pdata2 and pdata3 respectively.
- PWM write: req1 = 12'h980 -> `cmdata`=12'h980 for 2 cycles, `rsp_valid[1]` with `rsp_data`=8'h00.
- Watchdog (macro defined, WDOG_CYCLES=16, no writes; req0 asserted once the trip is pending) -> `cmdata` sequence 12'h900, 12'hA00, 12'hB00, 12'hC00 with `wdog_trip`=1 and `req_ready`=0 throughout; req0 is granted after STOP exits.
- Reset during HOLD of 12'h400 -> `cmdata`=12'h000 immediately and no `rsp_valid`; after release, requester 0 wins against requester 1.
